// File: rtl/ysyx_exu_issue_q_if.sv
// IDU->EXU decoded-instruction bundle. The "in" view is the consumer side and
// the "out" view is the producer side, as seen from the module holding the port.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

interface idu_pipe_if;
    logic [31:0]               pc;
    logic [31:0]               inst;
    logic [31:0]               op1;
    logic [31:0]               op2;
    logic [31:0]               opj;
    logic [31:0]               imm;
    logic [4:0]                alu_op;
    logic [`YSYX_REG_LEN-1:0]  rd;
    logic                      ren;
    logic                      wen;
    logic                      jen;
    logic                      ben;
    logic [2:0]                func3;
    logic                      system;
    logic                      func3_z;
    logic                      csr_wen;
    logic                      ebreak;
    logic                      ecall;
    logic                      mret;

    modport in (
        input pc, inst, op1, op2, opj, imm, alu_op, rd, ren, wen, jen, ben,
              func3, system, func3_z, csr_wen, ebreak, ecall, mret
    );
    modport out (
        output pc, inst, op1, op2, opj, imm, alu_op, rd, ren, wen, jen, ben,
               func3, system, func3_z, csr_wen, ebreak, ecall, mret
    );
endinterface

// File: rtl/ysyx_exu_issue_q.sv
// In-order IDU->EXU issue FIFO; min latency 1 cycle, no bypass.
// in_ready from registered count and flush only; system heads wait for exu_idle.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

module ysyx_exu_issue_q #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    idu_pipe_if.in           idu,
    input  logic             in_valid,
    output logic             in_ready,
    idu_pipe_if.out          exu,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    input  logic             exu_idle,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              inst;
        logic [31:0]              op1;
        logic [31:0]              op2;
        logic [31:0]              opj;
        logic [31:0]              imm;
        logic [4:0]               alu_op;
        logic [`YSYX_REG_LEN-1:0] rd;
        logic                     ren;
        logic                     wen;
        logic                     jen;
        logic                     ben;
        logic [2:0]               func3;
        logic                     system;
        logic                     func3_z;
        logic                     csr_wen;
        logic                     ebreak;
        logic                     ecall;
        logic                     mret;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    entry_t in_ent;
    entry_t head;
    logic   push;
    logic   pop;

    assign in_ent = '{pc: idu.pc, inst: idu.inst, op1: idu.op1, op2: idu.op2,
                      opj: idu.opj, imm: idu.imm, alu_op: idu.alu_op, rd: idu.rd,
                      ren: idu.ren, wen: idu.wen, jen: idu.jen, ben: idu.ben,
                      func3: idu.func3, system: idu.system, func3_z: idu.func3_z,
                      csr_wen: idu.csr_wen, ebreak: idu.ebreak, ecall: idu.ecall,
                      mret: idu.mret};

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (count_q != FULL) & ~flush;
    // system covers csr/ecall/ebreak/mret, so one bit gates serialization
    assign out_valid = (count_q != '0) & (~head.system | exu_idle) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_ent;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // storage is left intact on flush; only the bookkeeping resets
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign exu.pc      = head.pc;
    assign exu.inst    = head.inst;
    assign exu.op1     = head.op1;
    assign exu.op2     = head.op2;
    assign exu.opj     = head.opj;
    assign exu.imm     = head.imm;
    assign exu.alu_op  = head.alu_op;
    assign exu.rd      = head.rd;
    assign exu.ren     = head.ren;
    assign exu.wen     = head.wen;
    assign exu.jen     = head.jen;
    assign exu.ben     = head.ben;
    assign exu.func3   = head.func3;
    assign exu.system  = head.system;
    assign exu.func3_z = head.func3_z;
    assign exu.csr_wen = head.csr_wen;
    assign exu.ebreak  = head.ebreak;
    assign exu.ecall   = head.ecall;
    assign exu.mret    = head.mret;

endmodule

// File: tb/tb_ysyx_exu_issue_q.sv
// Scoreboard bench for ysyx_exu_issue_q: a queue model predicts handshakes,
// occupancy and the bundle presented at every pop.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

module tb_ysyx_exu_issue_q;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int RL    = `YSYX_REG_LEN;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [31:0]   op1;
        logic [31:0]   op2;
        logic [31:0]   opj;
        logic [31:0]   imm;
        logic [4:0]    alu_op;
        logic [RL-1:0] rd;
        logic          ren;
        logic          wen;
        logic          jen;
        logic          ben;
        logic [2:0]    func3;
        logic          system;
        logic          func3_z;
        logic          csr_wen;
        logic          ebreak;
        logic          ecall;
        logic          mret;
    } bundle_t;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic           flush;
    logic           exu_idle;
    logic [PTR_W:0] count;

    bundle_t drv;
    bundle_t obs;
    bundle_t q[$];

    int n_checks = 0;
    int n_errors = 0;

    idu_pipe_if idu_i ();
    idu_pipe_if exu_i ();

    ysyx_exu_issue_q #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .idu       (idu_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exu       (exu_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .exu_idle  (exu_idle),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign idu_i.pc      = drv.pc;
    assign idu_i.inst    = drv.inst;
    assign idu_i.op1     = drv.op1;
    assign idu_i.op2     = drv.op2;
    assign idu_i.opj     = drv.opj;
    assign idu_i.imm     = drv.imm;
    assign idu_i.alu_op  = drv.alu_op;
    assign idu_i.rd      = drv.rd;
    assign idu_i.ren     = drv.ren;
    assign idu_i.wen     = drv.wen;
    assign idu_i.jen     = drv.jen;
    assign idu_i.ben     = drv.ben;
    assign idu_i.func3   = drv.func3;
    assign idu_i.system  = drv.system;
    assign idu_i.func3_z = drv.func3_z;
    assign idu_i.csr_wen = drv.csr_wen;
    assign idu_i.ebreak  = drv.ebreak;
    assign idu_i.ecall   = drv.ecall;
    assign idu_i.mret    = drv.mret;

    assign obs = '{pc: exu_i.pc, inst: exu_i.inst, op1: exu_i.op1, op2: exu_i.op2,
                   opj: exu_i.opj, imm: exu_i.imm, alu_op: exu_i.alu_op, rd: exu_i.rd,
                   ren: exu_i.ren, wen: exu_i.wen, jen: exu_i.jen, ben: exu_i.ben,
                   func3: exu_i.func3, system: exu_i.system, func3_z: exu_i.func3_z,
                   csr_wen: exu_i.csr_wen, ebreak: exu_i.ebreak, ecall: exu_i.ecall,
                   mret: exu_i.mret};

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [RL-1:0] rd, input logic [31:0] imm,
                                   input logic sys, input logic mret);
        bundle_t b;
        b        = '0;
        b.pc     = pc;
        b.inst   = inst;
        b.rd     = rd;
        b.imm    = imm;
        b.system = sys;
        b.mret   = mret;
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        b.system = ($urandom_range(0, 3) == 0);
        return b;
    endfunction

    // One cycle: check combinational handshakes against the model, compare the
    // head on a pop, advance the model at the edge, then check occupancy.
    task automatic step();
        bit      er, ev;
        bundle_t h;
        #1;
        h  = (q.size() != 0) ? q[0] : '0;
        er = (q.size() != DEPTH) && !flush;
        ev = (q.size() != 0) && (!h.system || exu_idle) && !flush;
        chk("in_ready", 256'(in_ready), 256'(er));
        chk("out_valid", 256'(out_valid), 256'(ev));
        if (ev && out_ready) chk("pop_data", 256'(obs), 256'(h));
        @(posedge clock);
        if (flush) begin
            q.delete();
        end else begin
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) q.push_back(drv);
        end
        #1;
        chk("count", 256'(count), 256'(q.size()));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exu_idle  = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) step();
        chk("drain_count", 256'(count), 256'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        exu_idle  = 1'b1;
        drv       = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_count", 256'(count), 256'd0);
        chk("rst_pc", 256'(exu_i.pc), 256'd0);
        chk("rst_inst", 256'(exu_i.inst), 256'd0);
        reset = 1'b1;
        #1;
        chk("idle_in_ready", 256'(in_ready), 256'd1);

        // single pass-through
        drv       = mk(32'h8000_0000, 32'h0050_0093, RL'(1), 32'd5, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("pass_count", 256'(count), 256'd0);

        // fill to full, then release with a fifth entry wrapping the pointers
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drv      = mk(32'h100 + 32'(4 * i), 32'h13 + 32'(i), RL'(i + 2), 32'(i), 1'b0, 1'b0);
            in_valid = 1'b1;
            step();
        end
        chk("full_count", 256'(count), 256'd4);
        chk("full_in_ready", 256'(in_ready), 256'd0);
        drv       = mk(32'h110, 32'h17, RL'(6), 32'd4, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4 && in_valid; i++) begin
            step();
            if (q.size() != 0 && q[q.size() - 1].pc == 32'h110) in_valid = 1'b0;
        end
        chk("wrap_accept", 256'(in_valid), 256'd0);
        drain();

        // simultaneous push and pop at count 2
        out_ready = 1'b0;
        drv = mk(32'h120, 32'h1, RL'(7), 32'd0, 1'b0, 1'b0); in_valid = 1'b1; step();
        drv = mk(32'h124, 32'h2, RL'(8), 32'd0, 1'b0, 1'b0); step();
        drv = mk(32'h128, 32'h3, RL'(9), 32'd0, 1'b0, 1'b0); out_ready = 1'b1; step();
        chk("pp_count", 256'(count), 256'd2);
        chk("pp_head_pc", 256'(exu_i.pc), 256'h124);
        drain();

        // serialization: mret head waits for an idle EXU
        exu_idle  = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drv = mk(32'h12C, 32'h3020_0073, RL'(0), 32'd0, 1'b1, 1'b1); step();
        drv = mk(32'h130, 32'h4, RL'(3), 32'd0, 1'b0, 1'b0); step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("ser_count", 256'(count), 256'd2);
        exu_idle = 1'b1;
        #1;
        chk("ser_release", 256'(out_valid), 256'd1);
        chk("ser_head_mret", 256'(exu_i.mret), 256'd1);
        step();
        drain();

        // flush colliding with push and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv = mk(32'h140 + 32'(4 * i), 32'h5, RL'(4), 32'd0, 1'b0, 1'b0);
            step();
        end
        drv       = mk(32'h150, 32'h6, RL'(5), 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_count", 256'(count), 256'd0);
        drv      = mk(32'h200, 32'h7, RL'(10), 32'd9, 1'b0, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("flush_first_pc", 256'(exu_i.pc), 256'h200);
        drain();

        // random traffic with occasional flushes and system heads
        for (int i = 0; i < 200; i++) begin
            drv       = rnd_bundle();
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 1);
            exu_idle  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_exu_issue_q.md
Name: ysyx_exu_issue_q

Overview:
- Receive-side buffer for the IDU→EXU decoded-instruction bundle.
- Accepts bundles driven on an `idu_pipe_if.in` port and queues them in an in-order FIFO.
- Re-presents them to the EXU on an `idu_pipe_if.out` port with a valid/ready handshake.
- Decouples IDU stalls from EXU stalls.
- Enforces serialization of system instructions: they leave only when the EXU is idle.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clock  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- idu  interface  idu_pipe_if.in  decoded bundle from IDU.
- in_valid  input  1  idu bundle valid this cycle.
- in_ready  output  1  queue can accept a bundle this cycle.
- exu  interface  idu_pipe_if.out  head bundle toward EXU.
- out_valid  output  1  head bundle valid and releasable.
- out_ready  input  1  EXU accepts head this cycle.
- flush  input  1  discard all queued entries (redirect/trap).
- exu_idle  input  1  EXU has no instruction in flight.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Payload: every field of idu_pipe_if is packed per entry, 210+`YSYX_REG_LEN` bits.
  - Fields: pc, inst, op1, op2, opj, imm (32 each); alu_op 5; rd `YSYX_REG_LEN`; ren, wen, jen, ben; func3 3; system, func3_z, csr_wen, ebreak, ecall, mret.
  - Fields are stored and returned unmodified, bit-exact.
- Reset (reset=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, out_valid=0.
  - All storage cleared to 0, so every exu field reads 0.
- push = in_valid & in_ready.
  - On push, the idu bundle is written at wr_ptr and wr_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH) & ~flush.
  - It depends only on registered count and flush.
  - There is no combinational path from out_ready.
  - A full queue does not accept in the same cycle it pops.
- Head releasable:
  - Condition: count != 0 & (~head.system | exu_idle).
  - head.system covers csr/ecall/ebreak/mret, since decode sets system for all of them.
  - out_valid = releasable & ~flush.
- pop = out_valid & out_ready.
  - On pop, rd_ptr increments modulo DEPTH.
- exu fields are driven combinationally from entry[rd_ptr] at all times.
  - Their value is meaningful only when out_valid=1.
  - When count=0 they show the last-written/cleared slot.
- Latency: minimum 1 cycle.
  - A bundle pushed at edge N can appear with out_valid=1 in cycle N+1.
  - There is no same-cycle bypass.
- Count update per edge:
  - push only: count+1.
  - pop only: count−1.
  - push & pop both: unchanged, both pointers advance.
- Wrap-around: pointers wrap DEPTH−1→0; count disambiguates full from empty.
- flush=1 at an edge:
  - wr_ptr=rd_ptr=0, count=0.
  - Storage is not cleared.
  - flush overrides push and pop in the same cycle: nothing is accepted or released.
- Serialization hold:
  - While head.system=1 and exu_idle=0, out_valid=0 and the head stays put.
  - Pushes behind it continue until full.
- out_valid may drop without a pop only on flush, or when exu_idle falls while the head is system.
  - The EXU must sample only on out_valid & out_ready.
- count output = registered occupancy.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release.
  - Required: out_valid=0, count=0, in_ready=1, exu.pc=0, exu.inst=0.
- Single pass-through: push pc=0x80000000, inst=0x00500093, rd=1, imm=5, alu_op=0, with out_ready=1.
  - Required: next cycle out_valid=1 with identical fields; after the pop edge count=0.
- Fill and wrap, DEPTH=4, out_ready=0:
  - Push pc=0x100,0x104,0x108,0x10C. Required: count=4, in_ready=0.
  - Set out_ready=1, then push 0x110 when in_ready returns. Required: pops in order 0x100..0x110, rd_ptr wraps, no loss or duplication.
- Simultaneous push/pop at count=2:
  - Required: count stays 2 and the next head is the correct successor.
- Serialization: head inst=0x30200073 (mret, system=1, mret=1), exu_idle=0 for 5 cycles.
  - Required: out_valid=0 throughout, count unchanged.
  - exu_idle=1. Required: out_valid=1 the same cycle and the mret pops.
- Flush collision: count=3, with in_valid=1, out_ready=1, flush=1 in the same cycle.
  - Required: in_ready=0 and out_valid=0 during flush; next cycle count=0, out_valid=0.
  - Required: a subsequent push pc=0x200 emerges as the first entry.
